// File: rtl/sfp_test_pkg.sv
// Shared types, timing constants and helpers for the SFP test system.
package sfp_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PULSE,
    S_GAP
  } sched_state_t;

  // Width of the shared wait/pulse/gap down-counter.
  localparam int TIMER_W   = 32;
  localparam int MAX_PORTS = 32;

`ifdef TEST
  localparam int unsigned SEND_PERIOD = 32'd16;
  localparam int unsigned SEND_GAP    = 32'd8;
`else
  localparam int unsigned SEND_PERIOD = 32'h05F5E100;
  localparam int unsigned SEND_GAP    = 32'h01000000;
`endif

  // Index of the lowest set bit, -1 when the vector is empty.
  function automatic int lowest_set_idx(input logic [MAX_PORTS-1:0] v);
    int idx;
    idx = -1;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/pkt_send_scheduler_if.sv
// Control and status bundle between the system top and the send scheduler.
interface pkt_send_scheduler_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 25,
  parameter int CNT_W   = 16
);

  logic                        mac_inited;
  logic                        rx_ready;
  logic [N_PORTS-1:0]          port_en;
  logic                        force_round;
  logic [N_PORTS-1:0]          cmd_send;
  logic [N_PORTS*ADDR_W-1:0]   start_ram_addr;
  logic [N_PORTS*CNT_W-1:0]    sent_cnt;
  logic                        busy;

  // The scheduler side issues commands; the system side supplies readiness.
  modport master (
    input  mac_inited, rx_ready, port_en, force_round,
    output cmd_send, start_ram_addr, sent_cnt, busy
  );

  modport slave (
    output mac_inited, rx_ready, port_en, force_round,
    input  cmd_send, start_ram_addr, sent_cnt, busy
  );

endinterface

// File: rtl/pkt_send_scheduler.sv
// Periodic per-port send-command sequencer for the send-packet engines.
// One shared down-counter times the wait, pulse and gap phases.
module pkt_send_scheduler
  import sfp_test_pkg::*;
#(
  parameter int                N_PORTS    = 2,
  parameter int                ADDR_W     = 25,
  parameter int unsigned       PERIOD     = SEND_PERIOD,
  parameter int unsigned       GAP        = SEND_GAP,
  parameter int                PULSE_LEN  = 3,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(1),
  parameter int                CNT_W      = 16
) (
  input logic                  clk,
  input logic                  reset,
  pkt_send_scheduler_if.master bus
);

  sched_state_t              state_q, state_d;
  logic [TIMER_W-1:0]        cnt_q, cnt_d;
  logic [N_PORTS-1:0]        mask_q, mask_d;
  logic [N_PORTS-1:0]        cmd_q, cmd_d;
  logic [N_PORTS*ADDR_W-1:0] addr_q, addr_d;
  logic [N_PORTS*CNT_W-1:0]  sent_q, sent_d;
  logic                      busy_q, busy_d;

  logic                      run;
  logic                      start_pulse;
  logic [N_PORTS-1:0]        pick_src;
  logic [N_PORTS-1:0]        pick;
  logic [MAX_PORTS-1:0]      pick_ext;
  int                        sel_idx;

  assign run = bus.mac_inited & bus.rx_ready;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    sent_d      = sent_q;
    start_pulse = 1'b0;
    pick_src    = '0;
    pick_ext    = '0;
    pick        = '0;
    sel_idx     = 0;

    if (state_q != S_IDLE && !run) begin
      // Losing readiness truncates any pulse; counters and addresses survive.
      state_d = S_IDLE;
      cnt_d   = '0;
      mask_d  = '0;
      cmd_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run) begin
            state_d = S_WAIT;
            cnt_d   = TIMER_W'(PERIOD - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0 || bus.force_round) begin
            if (bus.port_en != '0) begin
              start_pulse = 1'b1;
              pick_src    = bus.port_en;
            end else begin
              mask_d = '0;
              cnt_d  = TIMER_W'(PERIOD - 1);
            end
          end else begin
            cnt_d = cnt_q - TIMER_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cmd_d   = '0;
            cnt_d   = TIMER_W'(GAP - 1);
          end else begin
            cnt_d = cnt_q - TIMER_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            if (mask_q != '0) begin
              start_pulse = 1'b1;
              pick_src    = mask_q;
            end else begin
              state_d = S_WAIT;
              cnt_d   = TIMER_W'(PERIOD - 1);
            end
          end else begin
            cnt_d = cnt_q - TIMER_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    pick_ext[N_PORTS-1:0] = pick_src;
    sel_idx               = lowest_set_idx(pick_ext);
    for (int i = 0; i < N_PORTS; i++) begin
      pick[i] = (sel_idx == i);
    end

    if (start_pulse) begin
      // The served bit is dropped from the mask as the pulse is launched.
      state_d = S_PULSE;
      cnt_d   = TIMER_W'(PULSE_LEN - 1);
      cmd_d   = pick;
      mask_d  = pick_src & ~pick;
      for (int i = 0; i < N_PORTS; i++) begin
        if (pick[i]) begin
          addr_d[i*ADDR_W +: ADDR_W] = START_ADDR;
          sent_d[i*CNT_W +: CNT_W]   = sent_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end

    busy_d = (state_d == S_PULSE) || (state_d == S_GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      sent_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cmd_send       = cmd_q;
  assign bus.start_ram_addr = addr_q;
  assign bus.sent_cnt       = sent_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_pkt_send_scheduler.sv
// Directed bench for pkt_send_scheduler with short PERIOD/GAP and a 4-bit sent counter.
module tb_pkt_send_scheduler;

  localparam int N_PORTS   = 2;
  localparam int ADDR_W    = 25;
  localparam int CNT_W     = 4;
  localparam int PERIOD    = 16;
  localparam int GAP       = 8;
  localparam int PULSE_LEN = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int onehot_errs  = 0;

  pkt_send_scheduler_if #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pkt_send_scheduler #(
    .N_PORTS    (N_PORTS),
    .ADDR_W     (ADDR_W),
    .PERIOD     (PERIOD),
    .GAP        (GAP),
    .PULSE_LEN  (PULSE_LEN),
    .START_ADDR (25'd1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(bus.cmd_send)) else onehot_errs++;
    end
  end

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return bus.start_ram_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [CNT_W-1:0] sent_of(input int i);
    return bus.sent_cnt[i*CNT_W +: CNT_W];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ticks until cmd_send goes from zero to non-zero; ticks = -1 on timeout.
  task automatic next_pulse(output int ticks, output logic [N_PORTS-1:0] seen);
    logic [N_PORTS-1:0] prev;
    prev  = bus.cmd_send;
    ticks = -1;
    seen  = '0;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      if (bus.cmd_send != '0 && prev == '0) begin
        ticks = k;
        seen  = bus.cmd_send;
        break;
      end
      prev = bus.cmd_send;
    end
  endtask

  // Called on the first pulse cycle; returns on the first cycle after it.
  task automatic pulse_len(output int len);
    logic [N_PORTS-1:0] p;
    p   = bus.cmd_send;
    len = 1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (bus.cmd_send === p) len++;
      else break;
    end
  endtask

  task automatic test_reset();
    bus.mac_inited  = 1'b1;
    bus.rx_ready    = 1'b1;
    bus.port_en     = 2'b11;
    bus.force_round = 1'b0;
    #2 reset = 1'b1;
    tick(5);
    tests_run++;
    if (bus.cmd_send !== 2'b00 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cmd_busy: cmd_send=%b busy=%b, expected 00/0", bus.cmd_send, bus.busy);
    end
    tests_run++;
    if (bus.start_ram_addr !== '0 || bus.sent_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_addr_cnt: addr=%h cnt=%h, expected 0/0", bus.start_ram_addr, bus.sent_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    int t, len;
    logic [N_PORTS-1:0] s;
    next_pulse(t, s);
    tests_run++;
    if (t !== 17 || s !== 2'b01) begin
      tests_failed++;
      $display("FAIL first_pulse: ticks=%0d cmd=%b, expected 17/01", t, s);
    end
    tests_run++;
    if (addr_of(0) !== 25'd1 || sent_of(0) !== 4'd1 || addr_of(1) !== 25'd0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL port0_status: addr0=%0d cnt0=%0d addr1=%0d busy=%b, expected 1/1/0/1",
               addr_of(0), sent_of(0), addr_of(1), bus.busy);
    end
    pulse_len(len);
    tests_run++;
    if (len !== PULSE_LEN) begin
      tests_failed++;
      $display("FAIL port0_pulse_len: got %0d, expected %0d", len, PULSE_LEN);
    end
    tests_run++;
    if (bus.cmd_send !== 2'b00 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_busy: cmd=%b busy=%b, expected 00/1", bus.cmd_send, bus.busy);
    end
    next_pulse(t, s);
    tests_run++;
    if (t !== 8 || s !== 2'b10 || addr_of(1) !== 25'd1 || sent_of(1) !== 4'd1) begin
      tests_failed++;
      $display("FAIL port1_after_gap: ticks=%0d cmd=%b addr1=%0d cnt1=%0d, expected 8/10/1/1",
               t, s, addr_of(1), sent_of(1));
    end
    pulse_len(len);
    tests_run++;
    if (len !== PULSE_LEN) begin
      tests_failed++;
      $display("FAIL port1_pulse_len: got %0d, expected %0d", len, PULSE_LEN);
    end
    next_pulse(t, s);
    tests_run++;
    if (t !== 24 || s !== 2'b01 || sent_of(0) !== 4'd2) begin
      tests_failed++;
      $display("FAIL second_round: ticks=%0d cmd=%b cnt0=%0d, expected 24/01/2", t, s, sent_of(0));
    end
  endtask

  task automatic test_port_mask();
    int t, bad;
    logic [N_PORTS-1:0] s;
    bus.port_en = 2'b00;
    next_pulse(t, s);
    tests_run++;
    if (t !== 11 || s !== 2'b10 || sent_of(1) !== 4'd2) begin
      tests_failed++;
      $display("FAIL latched_mask: ticks=%0d cmd=%b cnt1=%0d, expected 11/10/2", t, s, sent_of(1));
    end
    bus.port_en = 2'b10;
    next_pulse(t, s);
    tests_run++;
    if (t !== 27 || s !== 2'b10 || sent_of(1) !== 4'd3 || sent_of(0) !== 4'd2) begin
      tests_failed++;
      $display("FAIL port1_only_a: ticks=%0d cmd=%b cnt1=%0d cnt0=%0d, expected 27/10/3/2",
               t, s, sent_of(1), sent_of(0));
    end
    next_pulse(t, s);
    tests_run++;
    if (t !== 27 || s !== 2'b10 || sent_of(1) !== 4'd4 || sent_of(0) !== 4'd2) begin
      tests_failed++;
      $display("FAIL port1_only_b: ticks=%0d cmd=%b cnt1=%0d cnt0=%0d, expected 27/10/4/2",
               t, s, sent_of(1), sent_of(0));
    end
    bus.port_en = 2'b00;
    tick(PULSE_LEN + GAP);
    tests_run++;
    if (bus.cmd_send !== 2'b00 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_to_wait: cmd=%b busy=%b, expected 00/0", bus.cmd_send, bus.busy);
    end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (bus.cmd_send !== 2'b00 || bus.busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL no_ports_quiet: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_force();
    int t;
    logic [N_PORTS-1:0] s;
    bus.rx_ready = 1'b0;
    tick(1);
    bus.rx_ready = 1'b1;
    tick(1);
    tick(5);
    tests_run++;
    if (bus.cmd_send !== 2'b00) begin
      tests_failed++;
      $display("FAIL pre_force_quiet: cmd=%b, expected 00", bus.cmd_send);
    end
    bus.force_round = 1'b1;
    bus.port_en     = 2'b11;
    tick(1);
    bus.force_round = 1'b0;
    tests_run++;
    if (bus.cmd_send !== 2'b01 || sent_of(0) !== 4'd3) begin
      tests_failed++;
      $display("FAIL force_start: cmd=%b cnt0=%0d, expected 01/3", bus.cmd_send, sent_of(0));
    end
    tick(4);
    tests_run++;
    if (bus.cmd_send !== 2'b00 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL force_gap_state: cmd=%b busy=%b, expected 00/1", bus.cmd_send, bus.busy);
    end
    bus.force_round = 1'b1;
    tick(1);
    bus.force_round = 1'b0;
    next_pulse(t, s);
    tests_run++;
    if (t !== 6 || s !== 2'b10 || sent_of(1) !== 4'd5) begin
      tests_failed++;
      $display("FAIL force_in_gap_port1: ticks=%0d cmd=%b cnt1=%0d, expected 6/10/5", t, s, sent_of(1));
    end
    next_pulse(t, s);
    tests_run++;
    if (t !== 27 || s !== 2'b01 || sent_of(0) !== 4'd4) begin
      tests_failed++;
      $display("FAIL force_not_queued: ticks=%0d cmd=%b cnt0=%0d, expected 27/01/4", t, s, sent_of(0));
    end
  endtask

  task automatic test_run_drop();
    int t;
    logic [N_PORTS-1:0] s;
    tick(1);
    bus.rx_ready = 1'b0;
    tick(1);
    tests_run++;
    if (bus.cmd_send !== 2'b00 || bus.busy !== 1'b0 || sent_of(0) !== 4'd4 || addr_of(0) !== 25'd1) begin
      tests_failed++;
      $display("FAIL run_drop_truncate: cmd=%b busy=%b cnt0=%0d addr0=%0d, expected 00/0/4/1",
               bus.cmd_send, bus.busy, sent_of(0), addr_of(0));
    end
    tick(1);
    bus.rx_ready = 1'b1;
    next_pulse(t, s);
    tests_run++;
    if (t !== 17 || s !== 2'b01 || sent_of(0) !== 4'd5) begin
      tests_failed++;
      $display("FAIL run_restore: ticks=%0d cmd=%b cnt0=%0d, expected 17/01/5", t, s, sent_of(0));
    end
  endtask

  task automatic test_async_reset();
    #3 reset = 1'b1;
    #1;
    tests_run++;
    if (bus.cmd_send !== 2'b00 || bus.busy !== 1'b0 || bus.sent_cnt !== '0 || bus.start_ram_addr !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_mid_pulse: cmd=%b busy=%b cnt=%h addr=%h, expected all 0",
               bus.cmd_send, bus.busy, bus.sent_cnt, bus.start_ram_addr);
    end
    bus.port_en = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    int t, exp_t;
    logic [N_PORTS-1:0] s;
    for (int n = 0; n < 16; n++) begin
      next_pulse(t, s);
      exp_t = (n == 0) ? 17 : 27;
      tests_run++;
      if (t !== exp_t || s !== 2'b10) begin
        tests_failed++;
        $display("FAIL wrap_pulse_%0d: ticks=%0d cmd=%b, expected %0d/10", n, t, s, exp_t);
      end
      if (n == 14) begin
        tests_run++;
        if (sent_of(1) !== 4'hF) begin
          tests_failed++;
          $display("FAIL cnt_at_max: cnt1=%h, expected f", sent_of(1));
        end
      end
    end
    tests_run++;
    if (sent_of(1) !== 4'h0 || sent_of(0) !== 4'h0) begin
      tests_failed++;
      $display("FAIL cnt_wrap: cnt1=%h cnt0=%h, expected 0/0", sent_of(1), sent_of(0));
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_port_mask();
    test_force();
    test_run_drop();
    test_async_reset();
    test_wrap();
    tests_run++;
    if (onehot_errs !== 0) begin
      tests_failed++;
      $display("FAIL cmd_onehot0: %0d violating cycles, expected 0", onehot_errs);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
